load_store_unit32: RTL and testbench

//   Initiator side of the 32-bit data-memory port. Accepts one load/store request at a time from the core.

---
 rtl/klp32_lsu_pkg.sv | 46 ++++
 rtl/lsu_byte_lane.sv | 84 ++++++++
 rtl/load_store_unit32.sv | 147 ++++++++++++++
 tb/tb_load_store_unit32.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/klp32_lsu_pkg.sv
// -----------------------------------------------------------------------------
// klp32_lsu_pkg
//   Shared definitions for the 32-bit load/store unit:
//     - RV32I load/store width codes (funct3)
//     - FSM state encoding
//     - MEM_AW, the word-address width consumed by the data memory
//     - req_bad(): flags misaligned accesses and illegal width codes
// -----------------------------------------------------------------------------
package klp32_lsu_pkg;

  // Word-address bits the data memory actually decodes (1024 words).
  localparam int MEM_AW = 10;

  // RV32I width codes.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } lsu_state_e;

  // Returns 1 when the request must be rejected without touching memory:
  // a halfword not on a 2-byte boundary, a word not on a 4-byte boundary,
  // a reserved width code, or an unsigned width code used with a store.
  function automatic logic req_bad(input logic       store,
                                   input logic [2:0] funct3,
                                   input logic [1:0] lane);
    logic bad;
    case (funct3)
      F3_B:    bad = 1'b0;
      F3_H:    bad = lane[0];
      F3_W:    bad = (lane != 2'b00);
      F3_BU:   bad = store;
      F3_HU:   bad = store | lane[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// -----------------------------------------------------------------------------
// lsu_byte_lane
//   Purely combinational byte-lane steering for the load/store unit.
//   Loads : picks the byte/halfword selected by lane out of the memory word and
//           sign- or zero-extends it according to funct3 (word passes through).
//   Stores: overlays the right-aligned store data onto the memory word at the
//           selected lane, producing the full word for a read-modify-write.
// Ports
//   funct3     in   3   width code of the latched request
//   lane       in   2   byte offset within the word (addr[1:0])
//   word       in   N   current memory word
//   wdata      in   N   right-aligned store data
//   load_data  out  N   extended load result
//   merged     out  N   word with store data merged in
// -----------------------------------------------------------------------------
module lsu_byte_lane
  import klp32_lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2:0]   funct3,
  input  logic [1:0]   lane,
  input  logic [N-1:0] word,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] load_data,
  output logic [N-1:0] merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfword loads are aligned, so only lane[1] selects the half.
  assign ld_byte = word[{lane, 3'b000} +: 8];
  assign ld_half = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(N-8){ld_byte[7]}}, ld_byte};
      F3_BU:   load_data = {{(N-8){1'b0}}, ld_byte};
      F3_H:    load_data = {{(N-16){ld_half[15]}}, ld_half};
      F3_HU:   load_data = {{(N-16){1'b0}}, ld_half};
      F3_W:    load_data = word;
      default: load_data = '0;
    endcase
  end

  // Per-byte merge: each output byte either keeps the memory byte or takes
  // the store byte that lands on it for the current width and lane.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] IDX = 2'(gi);
      logic       sel;
      logic [7:0] src;

      always_comb begin
        sel = 1'b0;
        src = wdata[7:0];
        case (funct3[1:0])
          2'b00: begin
            sel = (lane == IDX);
            src = wdata[7:0];
          end
          2'b01: begin
            sel = (lane[1] == IDX[1]);
            src = wdata[8*(gi%2) +: 8];
          end
          2'b10: begin
            sel = 1'b1;
            src = wdata[8*gi +: 8];
          end
          default: begin
            sel = 1'b0;
            src = wdata[7:0];
          end
        endcase
      end

      assign merged[8*gi +: 8] = sel ? src : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit32.sv
// -----------------------------------------------------------------------------
// load_store_unit32
//   Initiator side of the 32-bit data-memory port. Takes one load/store at a
//   time from the core, talks to a word-wide memory (combinational read,
//   posedge write) and returns the result on a valid/ready response.
//   Byte/half loads are lane-extracted; byte/half stores are done as a
//   read-modify-write (read in ACCESS, write the merged word in MERGE_WR).
//   Flow: IDLE -> ACCESS -> [MERGE_WR] -> RESP -> IDLE; rejected requests go
//   straight from IDLE to RESP with resp_err set.
// Ports
//   clk, rst_n                  clock / asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_store, req_funct3       operation and RV32I width code
//   req_addr, req_wdata         byte address, right-aligned store data
//   resp_valid/resp_ready       response handshake (valid held until ready)
//   resp_rdata, resp_err        extended load data / error flag
//   mem_we, mem_addr, mem_wdata memory write enable, word index, write word
//   mem_rdata                   combinational read data for mem_addr
// -----------------------------------------------------------------------------
module load_store_unit32
  import klp32_lsu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_store,
  input  logic [2:0]   req_funct3,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);

  lsu_state_e   state_reg;
  logic         store_reg;
  logic [2:0]   funct3_reg;
  logic [1:0]   lane_reg;
  logic [N-1:0] wdata_reg;

  logic [N-1:0] load_data;
  logic [N-1:0] merged_word;

  lsu_byte_lane #(.N(N)) u_lane (
    .funct3    (funct3_reg),
    .lane      (lane_reg),
    .word      (mem_rdata),
    .wdata     (wdata_reg),
    .load_data (load_data),
    .merged    (merged_word)
  );

  // Derived straight from the state register, so it is glitch-free.
  assign req_ready = (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      store_reg  <= 1'b0;
      funct3_reg <= 3'b000;
      lane_reg   <= 2'b00;
      wdata_reg  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            store_reg  <= req_store;
            funct3_reg <= req_funct3;
            lane_reg   <= req_addr[1:0];
            wdata_reg  <= req_wdata;
            if (req_bad(req_store, req_funct3, req_addr[1:0])) begin
              // Rejected: report at once, memory is never addressed.
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
              state_reg  <= RESP;
            end else begin
              // Upper address bits pass through; the memory decodes only
              // the low MEM_AW bits of the word index and aliases the rest.
              mem_addr <= {2'b00, req_addr[N-1:2]};
              // A full-word store needs no read, so it writes during ACCESS.
              if (req_store && (req_funct3 == F3_W)) begin
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end
              state_reg <= ACCESS;
            end
          end
        end

        ACCESS: begin
          mem_we <= 1'b0;
          if (!store_reg) begin
            resp_rdata <= load_data;
            resp_valid <= 1'b1;
            state_reg  <= RESP;
          end else if (funct3_reg == F3_W) begin
            resp_rdata <= '0;
            resp_valid <= 1'b1;
            state_reg  <= RESP;
          end else begin
            // mem_rdata is the current word; write back the merged copy.
            mem_wdata <= merged_word;
            mem_we    <= 1'b1;
            state_reg <= MERGE_WR;
          end
        end

        MERGE_WR: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
          resp_valid <= 1'b1;
          state_reg  <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            state_reg  <= IDLE;
          end
        end

        default: begin
          mem_we    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit32.sv
module tb_load_store_unit32;
  import klp32_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit32 #(.N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: combinational read, posedge write.
  logic [31:0] mem [0:(1<<MEM_AW)-1];
  logic [31:0] model_mem [0:(1<<MEM_AW)-1];
  int          we_count = 0;
  logic [31:0] last_we_idx = 0;

  assign mem_rdata = mem[mem_addr[MEM_AW-1:0]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[MEM_AW-1:0]] = mem_wdata;
      we_count    = we_count + 1;
      last_we_idx = mem_addr;
    end
  end

  // Scoreboard of expected responses.
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb_q[$];

  // Reference behaviour of one request against a memory word.
  function automatic void ref_model(input logic st, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    input logic [31:0] old,
                                    output logic err, output logic [31:0] rd,
                                    output logic [31:0] nw);
    logic illegal, mis;
    logic [31:0] sh, mask;
    int s;
    illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
              (st && (f3 == 3'd4 || f3 == 3'd5));
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    err = illegal || mis;
    rd  = 32'h0;
    nw  = old;
    s   = 8 * int'(a[1:0]);
    sh  = old >> s;
    if (!err && !st) begin
      case (f3)
        3'd0: rd = {{24{sh[7]}}, sh[7:0]};
        3'd4: rd = {24'h0, sh[7:0]};
        3'd1: rd = {{16{sh[15]}}, sh[15:0]};
        3'd5: rd = {16'h0, sh[15:0]};
        default: rd = old;
      endcase
    end
    if (!err && st) begin
      mask = (f3 == 3'd0) ? 32'h0000_00FF : (f3 == 3'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      nw = (old & ~(mask << s)) | ((wd & mask) << s);
    end
  endfunction

  // Drive one request, push its expectation, wait (bounded) for the response
  // and pop the expectation. lat counts posedges from the accept edge.
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] e_rdata, input logic e_err,
                       output logic [31:0] got_rdata, output logic got_err,
                       output logic [31:0] exp_rdata, output logic exp_err,
                       output int lat, output int writes);
    exp_t e;
    int w0;
    e.rdata = e_rdata;
    e.err   = e_err;
    sb_q.push_back(e);
    @(negedge clk);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    w0 = we_count;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_store  = $urandom_range(0, 1);
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom();
    req_wdata  = $urandom();
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    e = sb_q.pop_front();
    exp_rdata = e.rdata;
    exp_err   = e.err;
    writes    = we_count - w0;
    $display("txn st=%0d f3=%0d addr=%08h wdata=%08h -> rdata=%08h err=%0d lat=%0d writes=%0d",
             st, f3, a, wd, got_rdata, got_err, lat, writes);
  endtask

  task automatic retire();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got=%b exp=0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got=%08h exp=0", resp_rdata); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got=%08h exp=0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got=%08h exp=0", mem_wdata); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    logic [2:0]  f3s   [5] = '{F3_W, F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] addrs [5] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] exps  [5] = '{32'h8899AABB, 32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h00008899};
    logic [31:0] gr, er;
    logic ge, ee;
    int lat, wr;
    mem[4] = 32'h8899AABB;
    for (int i = 0; i < 5; i++) begin
      issue(1'b0, f3s[i], addrs[i], 32'hFFFF_FFFF, exps[i], 1'b0, gr, ge, er, ee, lat, wr);
      checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency got=%0d exp=2", i, lat); end
      checks++; if (gr !== er) begin errors++; $display("FAIL load%0d_rdata got=%08h exp=%08h", i, gr, er); end
      checks++; if (ge !== ee) begin errors++; $display("FAIL load%0d_err got=%b exp=%b", i, ge, ee); end
      checks++; if (wr != 0) begin errors++; $display("FAIL load%0d_mem_we got=%0d exp=0", i, wr); end
      retire();
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL load%0d_retire got valid=%b ready=%b exp valid=0 ready=1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3s   [3] = '{F3_B, F3_H, F3_W};
    logic [31:0] addrs [3] = '{32'h11, 32'h12, 32'h10};
    logic [31:0] wds   [3] = '{32'h123456CC, 32'h0000BEEF, 32'hDEADBEEF};
    logic [31:0] memx  [3] = '{32'h8899CCBB, 32'hBEEFAABB, 32'hDEADBEEF};
    int          lats  [3] = '{3, 3, 2};
    logic [31:0] gr, er;
    logic ge, ee;
    int lat, wr;
    for (int i = 0; i < 3; i++) begin
      mem[4] = 32'h8899AABB;
      issue(1'b1, f3s[i], addrs[i], wds[i], 32'h0, 1'b0, gr, ge, er, ee, lat, wr);
      checks++; if (lat != lats[i]) begin errors++; $display("FAIL store%0d_latency got=%0d exp=%0d", i, lat, lats[i]); end
      checks++; if (ge !== ee || gr !== er) begin errors++; $display("FAIL store%0d_resp got=%08h/%b exp=%08h/%b", i, gr, ge, er, ee); end
      checks++; if (wr != 1) begin errors++; $display("FAIL store%0d_we_pulses got=%0d exp=1", i, wr); end
      checks++; if (last_we_idx !== 32'd4) begin errors++; $display("FAIL store%0d_we_index got=%0d exp=4", i, last_we_idx); end
      checks++; if (mem[4] !== memx[i]) begin errors++; $display("FAIL store%0d_mem got=%08h exp=%08h", i, mem[4], memx[i]); end
      retire();
    end
  endtask

  task automatic test_errors();
    logic        sts   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s   [4] = '{F3_W, F3_H, 3'b011, F3_BU};
    logic [31:0] addrs [4] = '{32'h11, 32'h13, 32'h10, 32'h10};
    logic [31:0] gr, er;
    logic ge, ee;
    int lat, wr;
    mem[4] = 32'h8899AABB;
    for (int i = 0; i < 4; i++) begin
      issue(sts[i], f3s[i], addrs[i], 32'hCAFEF00D, 32'h0, 1'b1, gr, ge, er, ee, lat, wr);
      checks++; if (lat != 1) begin errors++; $display("FAIL err%0d_latency got=%0d exp=1", i, lat); end
      checks++; if (ge !== ee) begin errors++; $display("FAIL err%0d_flag got=%b exp=%b", i, ge, ee); end
      checks++; if (gr !== er) begin errors++; $display("FAIL err%0d_rdata got=%08h exp=%08h", i, gr, er); end
      checks++; if (wr != 0) begin errors++; $display("FAIL err%0d_mem_we got=%0d exp=0", i, wr); end
      retire();
    end
    checks++; if (mem[4] !== 32'h8899AABB) begin errors++; $display("FAIL err_mem_untouched got=%08h exp=8899aabb", mem[4]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] gr, er;
    logic ge, ee;
    int lat, wr, w0;
    mem[4] = 32'h8899AABB;
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h8899AABB, 1'b0, gr, ge, er, ee, lat, wr);
    checks++; if (gr !== er) begin errors++; $display("FAIL bp_rdata got=%08h exp=%08h", gr, er); end
    w0 = we_count;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      // A competing store while busy must be ignored.
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_W;
      req_addr = 32'h10; req_wdata = 32'h01020304;
      @(posedge clk);
      #1;
      checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h8899AABB || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%b rdata=%08h ready=%b exp valid=1 rdata=8899aabb ready=0",
                 c, resp_valid, resp_rdata, req_ready);
      end
    end
    req_valid = 1'b0;
    retire();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", resp_valid); end
    checks++; if (we_count != w0 || mem[4] !== 32'h8899AABB) begin
      errors++; $display("FAIL bp_ignored_req got writes=%0d mem=%08h exp writes=0 mem=8899aabb", we_count - w0, mem[4]);
    end
  endtask

  task automatic test_reset_merge();
    int w0;
    mem[4] = 32'h8899AABB;
    w0 = we_count;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = F3_B;
    req_addr = 32'h11; req_wdata = 32'h123456CC;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstm_in_merge got mem_we=%b exp=1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL rstm_mem_port got we=%b addr=%08h wdata=%08h exp 0/0/0", mem_we, mem_addr, mem_wdata);
    end
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL rstm_resp got ready=%b valid=%b err=%b rdata=%08h exp 1/0/0/0",
                         req_ready, resp_valid, resp_err, resp_rdata);
    end
    @(posedge clk);
    #1;
    checks++; if (we_count != w0 || mem[4] !== 32'h8899AABB) begin
      errors++; $display("FAIL rstm_no_write got writes=%0d mem=%08h exp 0 / 8899aabb", we_count - w0, mem[4]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic st;
    logic [2:0] f3;
    logic [31:0] a, wd, idx, nw, rd;
    logic er_m;
    logic [31:0] gr, er;
    logic ge, ee;
    int lat, wr, elat;
    for (int i = 0; i < (1 << MEM_AW); i++) begin
      mem[i]       = 32'h5A00_0000 ^ (i * 32'h0101_0107);
      model_mem[i] = 32'h5A00_0000 ^ (i * 32'h0101_0107);
    end
    for (int n = 0; n < 40; n++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      wd = $urandom();
      idx = {22'h0, a[11:2]};
      ref_model(st, f3, a, wd, model_mem[idx], er_m, rd, nw);
      model_mem[idx] = nw;
      elat = er_m ? 1 : ((st && f3 != F3_W) ? 3 : 2);
      issue(st, f3, a, wd, rd, er_m, gr, ge, er, ee, lat, wr);
      checks++; if (gr !== er || ge !== ee || lat != elat) begin
        errors++; $display("FAIL b2b%0d got rdata=%08h err=%b lat=%0d exp rdata=%08h err=%b lat=%0d",
                           n, gr, ge, lat, er, ee, elat);
      end
      checks++; if (wr != ((st && !er_m) ? 1 : 0) || mem[idx] !== model_mem[idx]) begin
        errors++; $display("FAIL b2b%0d_mem got writes=%0d word=%08h exp writes=%0d word=%08h",
                           n, wr, mem[idx], (st && !er_m) ? 1 : 0, model_mem[idx]);
      end
      retire();
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << MEM_AW); i++) mem[i] = 32'h0;
    test_reset();
    test_loads();
    test_stores();
    test_errors();
    test_backpressure();
    test_reset_merge();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
